nanov_sequencer: RTL and testbench
==================================

// Module: nanov_sequencer
// PURPOSE
//  Instruction sequencer for the bit-serial nanoV core. Accepts one 32-bit instruction at a time
//  from the fetch unit and owns the core's bit counter, pass index and PC. Drives the 0..31 bit
//  sweeps each instruction needs, samples the core's branch result and computes the next PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
// PORTS
//  clk          in   1   core clock, single domain
//  rst          in   1   reset: synchronous, active-high
//  fetch_valid  in   1   fetch_data holds a valid instruction
//  fetch_data   in   32  instruction word from fetch unit
//  fetch_ready  out  1   sequencer can accept an instruction this cycle
//  hold         in   1   freeze counter/pass/state (memory stall)
//  branch       in   1   core compare result (slt/sltu bit), valid at counter==31
//  instr        out  32  instruction presented to the core
//  counter      out  5   bit index of current serial sweep
//  cycle        out  2   pass index within instruction
//  exec         out  1   high while a sweep is in progress
//  pc           out  32  address of the instruction in instr
//  illegal      out  1   one-cycle pulse: unsupported instruction retired
// BEHAVIOUR
//  Reset: state FETCH, fetch_ready=1, instr=32'h0000_0013 (nop), counter=0, cycle=0, exec=0,
//   pc=RESET_PC, illegal=0. rst during EXEC aborts the instruction with no PC update.
//  States:
//   FETCH: fetch_ready=1. On fetch_valid: latch instr, counter=0, cycle=0, next EXEC.
//    Acceptance costs one cycle; counter 0 of the first sweep is the cycle after the handshake.
//   EXEC: fetch_ready=0, exec=1, counter+1 per clk unless hold. hold freezes counter/cycle/state.
//    hold is ignored in FETCH.
//    At counter==31 && !hold:
//     - If cycle==npass-1: retire, update pc, next FETCH.
//     - Otherwise cycle+1, counter wraps to 0.
//  Pass count npass by opcode (instr[6:2]):
//   - OP (01100), OP-IMM (00100): 1.
//   - Shifts (funct3[1:0]==01): 2 (pass 0 loads operand and shift amount, pass 1 writes rd).
//   - STORE (01000): 2.
//   - BRANCH (11000): 1.
//   - All others: 1, illegal.
//  Next PC, evaluated at the retire edge:
//   - BRANCH with funct3[2]==1 (blt/bge/bltu/bgeu): taken = branch ^ funct3[0].
//     taken -> pc + sext(B-imm) (13-bit, bit0=0), mod 2^32; else pc+4.
//   - BRANCH with funct3[2]==0 (beq/bne): unsupported; illegal, pc+4.
//   - Everything else: pc+4; wrap 32'hFFFF_FFFC -> 0.
//  illegal: pulses the cycle after retire, concurrent with fetch_ready reasserting.
//  hold at counter==31 of the last pass delays the retire and the branch sample; branch is sampled
//   on the non-held edge.
//  Outputs are registered. instr and pc remain stable from acceptance through retire.
//  instr holds its value in FETCH.
//  Back-to-back: FETCH lasts exactly one cycle when fetch_valid is already high.
//   Throughput for a 1-pass op is 33 clk per instruction.
// STRUCTURE
//  Package nanov_pkg:
//   - opcode constants OPC_OP, OPC_OP_IMM, OPC_STORE, OPC_BRANCH
//   - state enum {FETCH, EXEC}
//   - function npass(instr) returning 2'd1/2'd2
//   - function b_imm(instr) returning 32-bit sign-extended immediate
//  Sub-module nanov_pc_unit: pc register, +4 / +imm adder, taken select, reset to RESET_PC.
//  The rest (FSM, counter, pass index) is local.
// TESTING
//  1. addi x1,x0,5 (32'h0050_0093) after reset:
//     fetch_ready 1->0; counter 0..31 once; cycle=0; retire pc 0->4; illegal=0.
//  2. slli x2,x1,3 (32'h0030_9113):
//     two sweeps, cycle 0 then 1; 64 EXEC clk; pc+4.
//  3. blt (funct3=100), B-imm=-8, pc=0x20, branch=1 at counter 31: pc->0x18.
//     Same with branch=0: pc->0x24. bge, branch=0: taken.
//  4. hold high for 3 clk at counter==17 then at counter==31 of last pass:
//     counter frozen; total EXEC = 32+6 clk; branch sampled after hold drops.
//  5. Opcode 1101111 (jal) and beq:
//     one sweep; illegal pulse one clk; pc+4; next fetch accepted.
//  6. rst asserted at counter==10 of a taken branch:
//     next cycle pc=RESET_PC, FETCH, instr=nop, no illegal pulse.

Source files
------------

// File: rtl/nanov_pkg.sv
// Shared opcode constants, sequencer state type and instruction decode helpers
// for the bit-serial nanoV sequencer.
package nanov_pkg;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {FETCH, EXEC} state_e;

  // Shifts need an extra sweep: the first pass loads the operand and shift amount.
  function automatic logic [1:0] npass(input logic [31:0] instr);
    logic [4:0] opc;
    opc = instr[6:2];
    if ((opc == OPC_OP || opc == OPC_OP_IMM) && instr[13:12] == 2'b01) return 2'd2;
    if (opc == OPC_STORE) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic is_illegal(input logic [31:0] instr);
    logic [4:0] opc;
    opc = instr[6:2];
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_STORE: return 1'b0;
      OPC_BRANCH:                    return ~instr[14];
      default:                       return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/nanov_pc_unit.sv
// Program counter register with sequential (+4) and branch-target (+B-imm) update,
// committed only on the retire edge.
module nanov_pc_unit
  import nanov_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic        cond_br,
  input  logic        invert,
  input  logic [31:0] imm,
  input  logic        branch,
  output logic [31:0] pc
);

  logic        taken;
  logic [31:0] pc_next;

  // bge/bgeu invert the slt/sltu result the core delivers on branch.
  assign taken   = cond_br & (branch ^ invert);
  assign pc_next = taken ? pc + imm : pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst)         pc <= RESET_PC;
    else if (retire) pc <= pc_next;
  end

endmodule

// File: rtl/nanov_sequencer.sv
// Instruction sequencer for the bit-serial nanoV core: accepts instructions, sweeps
// the 0..31 bit counter once per pass and retires with the next PC.
module nanov_sequencer
  import nanov_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        hold,
  input  logic        branch,
  output logic [31:0] instr,
  output logic [4:0]  counter,
  output logic [1:0]  cycle,
  output logic        exec,
  output logic [31:0] pc,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_d;
  logic [4:0]  counter_d;
  logic [1:0]  cycle_d;
  logic        illegal_d;
  logic        retire;
  logic        cond_br;

  assign fetch_ready = (state_q == FETCH);
  assign exec        = (state_q == EXEC);
  assign cond_br     = (instr[6:2] == OPC_BRANCH) & instr[14];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      instr   <= INSTR_NOP;
      counter <= 5'd0;
      cycle   <= 2'd0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      instr   <= instr_d;
      counter <= counter_d;
      cycle   <= cycle_d;
      illegal <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr;
    counter_d = counter;
    cycle_d   = cycle;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        if (fetch_valid) begin
          instr_d   = fetch_data;
          counter_d = 5'd0;
          cycle_d   = 2'd0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (!hold) begin
          counter_d = counter + 5'd1;
          if (counter == 5'd31) begin
            if (cycle == npass(instr) - 2'd1) begin
              retire    = 1'b1;
              illegal_d = is_illegal(instr);
              cycle_d   = 2'd0;
              state_d   = FETCH;
            end else begin
              cycle_d = cycle + 2'd1;
            end
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  nanov_pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .retire (retire),
    .cond_br(cond_br),
    .invert (instr[12]),
    .imm    (b_imm(instr)),
    .branch (branch),
    .pc     (pc)
  );

endmodule

// File: tb/tb_nanov_sequencer.sv
// Directed bench for nanov_sequencer: runs hand-encoded instructions through the
// sequencer and compares sweep length, PC and illegal pulses with fixed values.
module tb_nanov_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        hold;
  logic        branch;
  logic [31:0] instr;
  logic [4:0]  counter;
  logic [1:0]  cycle;
  logic        exec;
  logic [31:0] pc;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] SLLI = 32'h0030_9113; // slli x2,x1,3
  localparam logic [31:0] BLT  = 32'hFE20_CCE3; // blt x1,x2,-8
  localparam logic [31:0] BGE  = 32'hFE20_DCE3; // bge x1,x2,-8
  localparam logic [31:0] BEQ  = 32'hFE20_8CE3; // beq x1,x2,-8
  localparam logic [31:0] JAL  = 32'h0000_006F; // jal x0,0
  localparam logic [31:0] SW   = 32'h0020_A023; // sw x2,0(x1)

  always #5 clk = ~clk;

  nanov_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_ready(fetch_ready),
    .hold       (hold),
    .branch     (branch),
    .instr      (instr),
    .counter    (counter),
    .cycle      (cycle),
    .exec       (exec),
    .pc         (pc),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge with the sequencer in FETCH. Returns #1 after the
  // retire edge (or after the reset edge when rst_at matches a counter value).
  task automatic run(input logic [31:0] ins, input logic br, input int h17, input int h31,
                     input int rst_at, output int n);
    int          err;
    int          ec;
    int          ey;
    int          h17_left;
    int          h31_left;
    logic        hn;
    logic        rn;
    logic [31:0] p0;
    h17_left    = h17;
    h31_left    = h31;
    fetch_valid = 1'b1;
    fetch_data  = ins;
    @(posedge clk); #1;
    fetch_valid = 1'b0;
    fetch_data  = 32'h0;
    chk("accept_ready", {31'h0, fetch_ready}, 32'd0);
    n   = 0;
    err = 0;
    ec  = 0;
    ey  = 0;
    p0  = pc;
    while (exec && n < 200) begin
      if (counter != ec[4:0] || cycle != ey[1:0] || instr != ins || pc != p0) err++;
      n++;
      hn = 1'b0;
      if (counter == 5'd17 && h17_left > 0) begin
        hn = 1'b1;
        h17_left--;
      end else if (counter == 5'd31 && h31_left > 0) begin
        hn = 1'b1;
        h31_left--;
      end
      rn     = (int'(counter) == rst_at);
      hold   = hn;
      branch = (counter == 5'd31 && !hn) ? br : ~br;
      rst    = rn;
      @(posedge clk); #1;
      hold   = 1'b0;
      branch = 1'b0;
      if (rn) begin
        rst = 1'b0;
        break;
      end
      if (!hn) begin
        if (ec == 31) begin
          ec = 0;
          ey++;
        end else begin
          ec++;
        end
      end
    end
    chk("sweep_seq", err, 32'd0);
    chk("exec_done", {31'h0, exec}, 32'd0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    fetch_valid = 1'b0;
    fetch_data  = 32'h0;
    hold        = 1'b0;
    branch      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready",   {31'h0, fetch_ready}, 32'd1);
    chk("rst_instr",   instr,                NOP);
    chk("rst_counter", {27'h0, counter},     32'd0);
    chk("rst_cycle",   {30'h0, cycle},       32'd0);
    chk("rst_exec",    {31'h0, exec},        32'd0);
    chk("rst_pc",      pc,                   32'h0);
    chk("rst_illegal", {31'h0, illegal},     32'd0);

    // addi: one sweep, pc 0 -> 4
    run(ADDI, 1'b0, 0, 0, -1, n);
    chk("addi_len",     n,                    32'd32);
    chk("addi_pc",      pc,                   32'h4);
    chk("addi_illegal", {31'h0, illegal},     32'd0);
    chk("addi_ready",   {31'h0, fetch_ready}, 32'd1);
    chk("addi_instr",   instr,                ADDI);

    // slli: two sweeps, pc 4 -> 8
    run(SLLI, 1'b0, 0, 0, -1, n);
    chk("slli_len", n,  32'd64);
    chk("slli_pc",  pc, 32'h8);

    for (int i = 0; i < 6; i++) run(NOP, 1'b0, 0, 0, -1, n);
    chk("nop_pc", pc, 32'h20);

    // blt taken from 0x20 -> 0x18
    run(BLT, 1'b1, 0, 0, -1, n);
    chk("blt_t_len", n,                32'd32);
    chk("blt_t_pc",  pc,               32'h18);
    chk("blt_t_ill", {31'h0, illegal}, 32'd0);

    run(NOP, 1'b0, 0, 0, -1, n);
    run(NOP, 1'b0, 0, 0, -1, n);
    chk("back_pc", pc, 32'h20);

    // blt not taken 0x20 -> 0x24
    run(BLT, 1'b0, 0, 0, -1, n);
    chk("blt_nt_pc", pc, 32'h24);

    // bge with slt=0 is taken: 0x24 -> 0x1C
    run(BGE, 1'b0, 0, 0, -1, n);
    chk("bge_pc", pc, 32'h1C);

    // holds at counter 17 and 31; branch is only valid on the non-held edge
    run(BLT, 1'b1, 3, 3, -1, n);
    chk("hold_len", n,  32'd38);
    chk("hold_pc",  pc, 32'h14);

    // jal unsupported: illegal pulse for one cycle, pc+4
    run(JAL, 1'b0, 0, 0, -1, n);
    chk("jal_len",   n,                    32'd32);
    chk("jal_pc",    pc,                   32'h18);
    chk("jal_ill",   {31'h0, illegal},     32'd1);
    chk("jal_ready", {31'h0, fetch_ready}, 32'd1);
    @(posedge clk); #1;
    chk("jal_ill_off", {31'h0, illegal}, 32'd0);

    // beq unsupported: never taken even with branch=1
    run(BEQ, 1'b1, 0, 0, -1, n);
    chk("beq_len", n,                32'd32);
    chk("beq_pc",  pc,               32'h1C);
    chk("beq_ill", {31'h0, illegal}, 32'd1);

    // reset mid-way through a taken branch
    run(BLT, 1'b1, 0, 0, 10, n);
    chk("abort_len",     n,                    32'd11);
    chk("abort_pc",      pc,                   32'h0);
    chk("abort_ready",   {31'h0, fetch_ready}, 32'd1);
    chk("abort_instr",   instr,                NOP);
    chk("abort_ill",     {31'h0, illegal},     32'd0);
    chk("abort_counter", {27'h0, counter},     32'd0);

    run(ADDI, 1'b0, 0, 0, -1, n);
    chk("post_pc", pc, 32'h4);

    // store: two sweeps
    run(SW, 1'b0, 0, 0, -1, n);
    chk("sw_len", n,                32'd64);
    chk("sw_pc",  pc,               32'h8);
    chk("sw_ill", {31'h0, illegal}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
